// File: rtl/tlul_pkg.sv
// Shared TL-UL channel types built from the system TL widths.
package tlul_pkg;

    localparam int unsigned TL_AW  = 32;
    localparam int unsigned TL_DW  = 32;
    localparam int unsigned TL_AIW = 8;
    localparam int unsigned TL_DIW = 1;
    localparam int unsigned TL_AUW = 21;
    localparam int unsigned TL_DUW = 14;
    localparam int unsigned TL_SZW = 2;
    localparam int unsigned TL_DBW = TL_DW / 8;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic               a_valid;
        tl_a_op_e           a_opcode;
        logic [2:0]         a_param;
        logic [TL_SZW-1:0]  a_size;
        logic [TL_AIW-1:0]  a_source;
        logic [TL_AW-1:0]   a_address;
        logic [TL_DBW-1:0]  a_mask;
        logic [TL_DW-1:0]   a_data;
        logic [TL_AUW-1:0]  a_user;
        logic               d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic               d_valid;
        tl_d_op_e           d_opcode;
        logic [2:0]         d_param;
        logic [TL_SZW-1:0]  d_size;
        logic [TL_AIW-1:0]  d_source;
        logic [TL_DIW-1:0]  d_sink;
        logic [TL_DW-1:0]   d_data;
        logic [TL_DUW-1:0]  d_user;
        logic               d_error;
        logic               a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/tlul_src_table.sv
// Outstanding-request table: per-entry valid/source, lowest-index alloc and
// retire, source lookup and a registered count of valid entries.
module tlul_src_table
    import tlul_pkg::*;
#(
    parameter int unsigned Depth     = 4,
    parameter int unsigned CntW      = $clog2(Depth + 1),
    parameter bit          UniqueSrc = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              alloc_i,
    input  logic [TL_AIW-1:0] alloc_src_i,
    input  logic              retire_i,
    input  logic [TL_AIW-1:0] retire_src_i,
    input  logic [TL_AIW-1:0] lookup_src_i,
    output logic              full_o,
    output logic              lookup_hit_o,
    output logic              retire_hit_o,
    output logic [CntW-1:0]   count_o
);

    logic [Depth-1:0]  valid_q, valid_d;
    logic [TL_AIW-1:0] src_q [Depth];
    logic [TL_AIW-1:0] src_d [Depth];
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [Depth-1:0]  free_oh, ret_oh;
    logic              free_found, ret_found, alloc_ok, retire_ok, src_dup;

    always_comb begin
        free_oh      = '0;
        ret_oh       = '0;
        free_found   = 1'b0;
        ret_found    = 1'b0;
        lookup_hit_o = 1'b0;
        for (int unsigned i = 0; i < Depth; i++) begin
            if (!valid_q[i] && !free_found) begin
                free_oh[i] = 1'b1;
                free_found = 1'b1;
            end
            if (valid_q[i] && src_q[i] == retire_src_i && !ret_found) begin
                ret_oh[i] = 1'b1;
                ret_found = 1'b1;
            end
            if (valid_q[i] && src_q[i] == lookup_src_i) begin
                lookup_hit_o = 1'b1;
            end
        end
    end

    assign alloc_ok     = alloc_i & free_found;
    assign retire_ok    = retire_i & ret_found;
    assign full_o       = &valid_q;
    assign retire_hit_o = ret_found;
    assign count_o      = cnt_q;

    // Retire uses pre-update state, so a same-cycle alloc is never the one cleared.
    always_comb begin
        valid_d = valid_q;
        if (retire_ok) valid_d = valid_d & ~ret_oh;
        if (alloc_ok)  valid_d = valid_d | free_oh;
        for (int unsigned i = 0; i < Depth; i++) begin
            src_d[i] = src_q[i];
            if (alloc_ok && free_oh[i]) src_d[i] = alloc_src_i;
        end
        case ({alloc_ok, retire_ok})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= '0;
            cnt_q   <= '0;
            for (int unsigned i = 0; i < Depth; i++) src_q[i] <= '0;
        end else begin
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            for (int unsigned i = 0; i < Depth; i++) src_q[i] <= src_d[i];
        end
    end

    always_comb begin
        src_dup = 1'b0;
        for (int unsigned i = 0; i < Depth; i++) begin
            for (int unsigned j = i + 1; j < Depth; j++) begin
                if (valid_q[i] && valid_q[j] && src_q[i] == src_q[j]) src_dup = 1'b1;
            end
        end
    end

    a_no_alloc_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(alloc_i && full_o));
    a_unique_src: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(UniqueSrc && src_dup));
    a_cnt_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (int'(cnt_q) <= int'(Depth)) && (int'(cnt_q) == $countones(valid_q)));

endmodule

// File: rtl/tlul_outstanding_limiter.sv
// Zero-latency TL-UL stage limiting in-flight requests, stalling duplicate
// sources, flagging unexpected responses and providing a drain handshake.
module tlul_outstanding_limiter
    import tlul_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 4,
    parameter bit          EnSourceCheck  = 1'b1,
    localparam int unsigned CntW          = $clog2(MaxOutstanding + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  tl_h2d_t         tl_h_i,
    output tl_d2h_t         tl_h_o,
    output tl_h2d_t         tl_d_o,
    input  tl_d2h_t         tl_d_i,
    input  logic            drain_req_i,
    output logic            drain_ack_o,
    output logic [CntW-1:0] outstanding_o,
    output logic            err_unexp_rsp_o
);

    typedef enum logic [1:0] {
        ACTIVE,
        DRAINING,
        DRAINED
    } drain_state_e;

    drain_state_e state_q;
    logic         drain_ack_q, err_q;
    logic         full, lookup_hit, retire_hit, dup, a_block, a_hs, d_hs;

    // Gating sees only registered state and host fields, never same-cycle D.
    assign dup     = EnSourceCheck && lookup_hit;
    assign a_block = full | dup | (state_q != ACTIVE);
    assign a_hs    = tl_d_o.a_valid & tl_d_i.a_ready;
    assign d_hs    = tl_d_i.d_valid & tl_h_i.d_ready;

    always_comb begin
        tl_d_o         = tl_h_i;
        tl_d_o.a_valid = tl_h_i.a_valid & ~a_block;
        tl_h_o         = tl_d_i;
        tl_h_o.a_ready = tl_d_i.a_ready & ~a_block;
    end

    tlul_src_table #(
        .Depth     (MaxOutstanding),
        .CntW      (CntW),
        .UniqueSrc (EnSourceCheck)
    ) u_src_table (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .alloc_i      (a_hs),
        .alloc_src_i  (tl_h_i.a_source),
        .retire_i     (d_hs),
        .retire_src_i (tl_d_i.d_source),
        .lookup_src_i (tl_h_i.a_source),
        .full_o       (full),
        .lookup_hit_o (lookup_hit),
        .retire_hit_o (retire_hit),
        .count_o      (outstanding_o)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ACTIVE;
            drain_ack_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            err_q <= d_hs & ~retire_hit;
            case (state_q)
                ACTIVE: begin
                    if (drain_req_i) state_q <= DRAINING;
                end
                DRAINING: begin
                    if (!drain_req_i) begin
                        state_q <= ACTIVE;
                    end else if (outstanding_o == '0 && !d_hs) begin
                        state_q     <= DRAINED;
                        drain_ack_q <= 1'b1;
                    end
                end
                DRAINED: begin
                    if (!drain_req_i) begin
                        state_q     <= ACTIVE;
                        drain_ack_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ACTIVE;
                    drain_ack_q <= 1'b0;
                end
            endcase
        end
    end

    assign drain_ack_o     = drain_ack_q;
    assign err_unexp_rsp_o = err_q;

    a_ack_idle: assert property (@(posedge clk_i) disable iff (!rst_ni)
        drain_ack_o |-> (outstanding_o == '0));

endmodule

// File: doc/tlul_outstanding_limiter.md
Name: tlul_outstanding_limiter

Overview:
TL-UL pass-through stage between a host port and its crossbar port. It caps the number of in-flight A-channel requests and stalls any request whose a_source is already outstanding. It retires entries on D-channel responses, flags responses with no matching request, and supports a drain handshake so the host can be quiesced before clock or power gating. Both channels pass combinationally, so the stage adds zero cycles of latency.

Parameters:
MaxOutstanding, 4, number of tracking entries (range 1..16)
EnSourceCheck, 1, when 1, stall an A request whose a_source matches a valid entry

Ports:
clk_i  in  1  block clock
rst_ni  in  1  reset
tl_h_i  in  tl_h2d_t (107)  host request plus host d_ready
tl_h_o  out  tl_d2h_t (66)  response to host plus a_ready
tl_d_o  out  tl_h2d_t (107)  request to crossbar plus d_ready
tl_d_i  in  tl_d2h_t (66)  crossbar response plus a_ready
drain_req_i  in  1  level; request quiesce
drain_ack_o  out  1  level; no transactions outstanding and no new A accepted
outstanding_o  out  CntW=$clog2(MaxOutstanding+1)  number of valid entries
err_unexp_rsp_o  out  1  one-cycle pulse on a D handshake with no matching entry

Reset is synchronous and active-low: rst_ni sampled on the rising edge of clk_i; all state clears when rst_ni=0 at that edge.

Behaviour:
- Reset values: all entries invalid; outstanding_o=0; drain_ack_o=0; err_unexp_rsp_o=0; FSM in ACTIVE.
- A gating: a_block = full | dup | (state!=ACTIVE).
  - full = all entries valid.
  - dup = EnSourceCheck & any valid entry with source==tl_h_i.a_source.
  - tl_d_o.a_valid = tl_h_i.a_valid & !a_block.
  - tl_h_o.a_ready = tl_d_i.a_ready & !a_block.
  - All other A fields pass unmodified.
- a_block depends only on registered state and host fields, never on same-cycle D signals. A D retire therefore never unblocks A in the same cycle.
- A handshake (tl_d_o.a_valid & tl_d_i.a_ready): write a_source into the lowest-index invalid entry and set it valid.
- D path: all D fields and d_ready pass through unmodified; tl_h_o.d_valid = tl_d_i.d_valid.
- D handshake: the lowest-index valid entry whose source matches d_source is cleared. If none matches, pulse err_unexp_rsp_o next cycle; the response is still forwarded and no entry changes.
- Simultaneous A and D handshake in one cycle: allocation and retirement both apply, so outstanding_o is unchanged. The D match uses pre-update entry state, so a same-cycle A with the same source is never retired by that D.
- outstanding_o is registered and equals the popcount of valid entries. Updates: +1 on alloc only, -1 on retire only, else hold. It never wraps; the invariant 0..MaxOutstanding is asserted.
- FSM (registered):
  - ACTIVE: if drain_req_i, go to DRAINING.
  - DRAINING: A is blocked. When outstanding==0 and no D handshake is pending this cycle, go to DRAINED.
  - DRAINED: drain_ack_o=1, A stays blocked. When drain_req_i=0, go to ACTIVE and drain_ack_o falls the same cycle as the transition.
  - drain_req_i deasserting while DRAINING returns to ACTIVE.
  - drain_req_i asserted with zero outstanding: ACTIVE -> DRAINING -> DRAINED, so drain_ack_o rises 2 cycles after the request.
- A request already presented when drain begins is withdrawn: a_valid drops. This is legal at this internal boundary; the host holds its request.
- Reset mid-transaction: all entries clear. A late D after reset produces err_unexp_rsp_o; integration guarantees the crossbar resets together with this block.
- Assertions:
  - no A alloc while full;
  - at most one entry per source when EnSourceCheck=1;
  - drain_ack_o implies outstanding_o==0.

Decomposition:
- Shared package (tlul_pkg): tl_h2d_t and tl_d2h_t packed structs built from the system TL widths (AW=32, DW=32, AIW=8, DIW=1, AUW=21, DUW=14, SZW=2), plus TL opcode enum.
- Local to this block: typedef for drain FSM state (ACTIVE, DRAINING, DRAINED).
- One sub-module: tlul_src_table, which holds the entry valid/source registers and provides alloc, retire, find-free and match logic, plus a popcount output.
- Top level holds the gating, FSM and error pulse.

Test Plan:
- MaxOutstanding=4; issue sources 0x01..0x04 with d_ready=0, then a fifth (0x05) -> a_ready=0 and outstanding_o=4. Respond to 0x02 -> next cycle 0x05 is accepted and outstanding_o returns to 4.
- Issue 0x10 while 0x10 is outstanding -> stall. Respond to 0x10 -> second 0x10 is accepted the cycle after the response.
- Same-cycle A of 0x20 and D of 0x21 with 2 outstanding -> outstanding_o stays 2 and the entry for 0x20 is valid.
- D with d_source=0x7F and no matching entry -> err_unexp_rsp_o high exactly 1 cycle, response reaches host, outstanding_o unchanged.
- 3 outstanding, assert drain_req_i -> new A blocked and drain_ack_o=0. After the 3 responses, drain_ack_o=1 one cycle after the last retire. Deassert drain_req_i -> drain_ack_o=0 and A flows the same cycle.
- With 2 outstanding, drive rst_ni=0 for 1 cycle -> outstanding_o=0, drain_ack_o=0, and the FSM is in ACTIVE.
